mem_responder: RTL and testbench

Word-organised data memory that answers load/store requests from the processor's data port over a valid/ready request channel and a valid/ready response channel. It replaces the zero-latency data array with a responder that inserts a programmable number of wait states, applies byte strobes, and flags bad addresses. This lets the core be exercised against realistic memory timing.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_word_array.sv | 45 ++++
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, widths and address checking for the data-memory responder.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } stateT;

    // Misaligned or beyond the array; the full 30-bit word index is compared so high addresses never alias.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        logic [WORD_W-1:0] wordIdx;
        wordIdx = {2'b00, addr[WORD_W-1:2]};
        return (addr[1:0] != 2'b00) || (wordIdx >= depth);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage with async clear, byte-strobed write port and a registered read port.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic              capEn,
    input  logic              rdSel,
    input  logic [IDX_W-1:0]  wordIdx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Array clear on reset; only bytes with a set strobe are written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[wordIdx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register: captures the word for a good load, zero for stores and errors, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (capEn) begin
            rdata <= rdSel ? mem[wordIdx] : '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, accesses the array, then holds the response.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    stateT              state;
    logic [CNT_W-1:0]   cnt;
    logic               writeQ;
    logic [WORD_W-1:0]  addrQ;
    logic [WORD_W-1:0]  wdataQ;
    logic [STRB_W-1:0]  wstrbQ;

    logic               accessErr;
    logic               arrayCapEn;
    logic               arrayWrEn;
    logic               arrayRdSel;

    // Access decode from the latched request; only meaningful in ACCESS.
    assign accessErr  = addr_err(addrQ, DEPTH_WORDS);
    assign arrayCapEn = (state == ACCESS);
    assign arrayWrEn  = arrayCapEn && writeQ && !accessErr;
    assign arrayRdSel = arrayCapEn && !writeQ && !accessErr;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wrEn    (arrayWrEn),
        .capEn   (arrayCapEn),
        .rdSel   (arrayRdSel),
        .wordIdx (IDX_W'(addrQ[WORD_W-1:2])),
        .wdata   (wdataQ),
        .wstrb   (wstrbQ),
        .rdata   (rsp_rdata)
    );

    // Request/response FSM with wait counter, request latch and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            writeQ    <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            wstrbQ    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        writeQ    <= req_write;
                        addrQ     <= req_addr;
                        wdataQ    <= req_wdata;
                        wstrbQ    <= req_wstrb;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= accessErr;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboarded requests on a WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 throughput check.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: WAIT_CYCLES = 2, DEPTH_WORDS = 256
    logic        aReqValid, aReqReady, aReqWrite;
    logic [31:0] aReqAddr, aReqWdata;
    logic [3:0]  aReqWstrb;
    logic        aRspValid, aRspReady, aRspErr;
    logic [31:0] aRspRdata;

    // Instance B: WAIT_CYCLES = 0, DEPTH_WORDS = 256
    logic        bReqValid, bReqReady, bReqWrite;
    logic [31:0] bReqAddr, bReqWdata;
    logic [3:0]  bReqWstrb;
    logic        bRspValid, bRspReady, bRspErr;
    logic [31:0] bRspRdata;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dutA (
        .clk       (clk),
        .reset     (reset),
        .req_valid (aReqValid),
        .req_ready (aReqReady),
        .req_write (aReqWrite),
        .req_addr  (aReqAddr),
        .req_wdata (aReqWdata),
        .req_wstrb (aReqWstrb),
        .rsp_valid (aRspValid),
        .rsp_ready (aRspReady),
        .rsp_rdata (aRspRdata),
        .rsp_err   (aRspErr)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutB (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bReqValid),
        .req_ready (bReqReady),
        .req_write (bReqWrite),
        .req_addr  (bReqAddr),
        .req_wdata (bReqWdata),
        .req_wstrb (bReqWstrb),
        .rsp_valid (bRspValid),
        .rsp_ready (bRspReady),
        .rsp_rdata (bRspRdata),
        .rsp_err   (bRspErr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } expT;

    expT sbQ[$];
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request on instance A; expected response is queued at accept and checked when rsp_valid appears.
    task automatic doReq(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] expData, input logic expErr, input int stall);
        int  n;
        expT e;
        expT pushed;
        @(negedge clk);
        aReqValid = 1'b1;
        aReqWrite = wr;
        aReqAddr  = addr;
        aReqWdata = wdata;
        aReqWstrb = wstrb;
        n = 0;
        while (aReqReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        aReqValid = 1'b0;
        pushed.rdata = expData;
        pushed.err   = expErr;
        sbQ.push_back(pushed);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (aRspValid !== 1'b1 && n < 50);
        check({tag, " latency"}, 32'(n), 32'd3);
        e = sbQ.pop_front();
        check({tag, " rdata"}, aRspRdata, e.rdata);
        check({tag, " err"}, 32'(aRspErr), 32'(e.err));
        check({tag, " req_ready busy"}, 32'(aReqReady), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, " stall rsp_valid"}, 32'(aRspValid), 32'd1);
            check({tag, " stall rdata"}, aRspRdata, e.rdata);
            check({tag, " stall err"}, 32'(aRspErr), 32'(e.err));
            check({tag, " stall req_ready"}, 32'(aReqReady), 32'd0);
        end
        aRspReady = 1'b1;
        @(posedge clk);
        #1;
        aRspReady = 1'b0;
        check({tag, " req_ready after hs"}, 32'(aReqReady), 32'd1);
        check({tag, " rsp_valid after hs"}, 32'(aRspValid), 32'd0);
    endtask

    int acceptCyc[$];

    initial begin
        reset     = 1'b1;
        aReqValid = 1'b0; aReqWrite = 1'b0; aReqAddr = '0; aReqWdata = '0; aReqWstrb = '0; aRspReady = 1'b0;
        bReqValid = 1'b0; bReqWrite = 1'b0; bReqAddr = '0; bReqWdata = '0; bReqWstrb = '0; bRspReady = 1'b0;
        #12;
        check("reset req_ready", 32'(aReqReady), 32'd1);
        check("reset rsp_valid", 32'(aRspValid), 32'd0);
        check("reset rdata", aRspRdata, 32'h0);
        check("reset err", 32'(aRspErr), 32'd0);
        check("reset B req_ready", 32'(bReqReady), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        doReq("ld0",        1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'h0000_0000, 1'b0, 0);
        doReq("st10 full",  1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  4'hF, 32'h0000_0000, 1'b0, 0);
        doReq("st10 byte0", 1'b1, 32'h0000_0010, 32'h0000_0011,  4'h1, 32'h0000_0000, 1'b0, 0);
        doReq("ld10",       1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_BE11, 1'b0, 0);
        doReq("ld12 misal", 1'b0, 32'h0000_0012, 32'h0,          4'h0, 32'h0000_0000, 1'b1, 0);
        doReq("st400 oor",  1'b1, 32'h0000_0400, 32'hAAAA_AAAA,  4'hF, 32'h0000_0000, 1'b1, 0);
        doReq("ld0 again",  1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'h0000_0000, 1'b0, 0);
        doReq("st3fc last", 1'b1, 32'h0000_03FC, 32'h1234_5678,  4'hF, 32'h0000_0000, 1'b0, 0);
        doReq("ld3fc last", 1'b0, 32'h0000_03FC, 32'h0,          4'h0, 32'h1234_5678, 1'b0, 0);
        doReq("ld wrap",    1'b0, 32'hFFFF_FFFC, 32'h0,          4'h0, 32'h0000_0000, 1'b1, 0);
        doReq("st10 nostb", 1'b1, 32'h0000_0010, 32'hFFFF_FFFF,  4'h0, 32'h0000_0000, 1'b0, 0);
        doReq("ld10 stall", 1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hDEAD_BE11, 1'b0, 5);

        // Reset while a store sits in WAIT
        @(negedge clk);
        aReqValid = 1'b1; aReqWrite = 1'b1; aReqAddr = 32'h8; aReqWdata = 32'hCAFE_F00D; aReqWstrb = 4'hF;
        @(posedge clk);
        #1;
        aReqValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("midwait reset req_ready", 32'(aReqReady), 32'd1);
        check("midwait reset rsp_valid", 32'(aRspValid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midwait no rsp", 32'(aRspValid), 32'd0);
        doReq("ld8 after abort", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 0);
        doReq("ld10 cleared",    1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 0);

        // Instance B: back-to-back loads with req_valid and rsp_ready held high
        @(negedge clk);
        bReqValid = 1'b1; bReqWrite = 1'b0; bReqAddr = 32'h0; bRspReady = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bReqReady === 1'b1) acceptCyc.push_back(cyc);
            if (bRspValid === 1'b1) begin
                check("B rdata", bRspRdata, 32'h0);
                check("B err", 32'(bRspErr), 32'd0);
            end
            @(negedge clk);
        end
        bReqValid = 1'b0;
        bRspReady = 1'b0;
        check("B accept count", 32'(acceptCyc.size()), 32'd7);
        for (int i = 1; i < acceptCyc.size(); i++) begin
            check("B accept spacing", 32'(acceptCyc[i] - acceptCyc[i-1]), 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
